// File: rtl/chess_pkg.sv
// Shared types for the move-check controller: piece encoding, result codes and FSM states.
package chess_pkg;

    typedef enum logic [2:0] {
        PAWN   = 3'd0,
        KNIGHT = 3'd1,
        BISHOP = 3'd2,
        ROOK   = 3'd3,
        QUEEN  = 3'd4,
        KING   = 3'd5
    } piece_kind_e;

    localparam logic [3:0] EMPTY        = 4'd15;
    localparam int         COLOUR_BIT   = 3;
    localparam int         NUM_CHECKERS = 6;

    typedef enum logic [2:0] {
        OK          = 3'd0,
        SAME_SQ     = 3'd1,
        EMPTY_SRC   = 3'd2,
        OWN_CAPTURE = 3'd3,
        BAD_PIECE   = 3'd4,
        REJECTED    = 3'd5,
        TIMEOUT     = 3'd6
    } res_code_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRECHECK = 3'd1,
        DISPATCH = 3'd2,
        WAIT     = 3'd3,
        RESP     = 3'd4
    } fsm_state_e;

    function automatic logic [2:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/move_precheck.sv
// Combinational square deltas and cheap reject checks that need no piece-specific checker.
module move_precheck
    import chess_pkg::*;
(
    input  logic [2:0] old_x,
    input  logic [2:0] old_y,
    input  logic [2:0] new_x,
    input  logic [2:0] new_y,
    input  logic [3:0] src_piece,
    input  logic [3:0] dst_piece,
    output logic [2:0] h_delta,
    output logic [2:0] v_delta,
    output logic       reject,
    output logic [2:0] reject_code
);

    // Ordering of the if-chain is the priority: first matching reason is reported.
    always_comb begin
        h_delta     = abs_diff(new_x, old_x);
        v_delta     = abs_diff(new_y, old_y);
        reject      = 1'b1;
        reject_code = OK;
        if (old_x == new_x && old_y == new_y) begin
            reject_code = SAME_SQ;
        end else if (src_piece == EMPTY) begin
            reject_code = EMPTY_SRC;
        end else if (src_piece[2:0] > KING) begin
            reject_code = BAD_PIECE;
        end else if (dst_piece != EMPTY &&
                     dst_piece[COLOUR_BIT] == src_piece[COLOUR_BIT]) begin
            reject_code = OWN_CAPTURE;
        end else begin
            reject = 1'b0;
        end
    end

endmodule

// File: rtl/move_check_ctrl.sv
// Move-check controller: accepts a move, pre-rejects trivial cases, dispatches to one
// piece checker, waits with timeout and returns the verdict. Optional MOVE_CHECK_STATS_EN.
module move_check_ctrl
    import chess_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  old_x,
    input  logic [2:0]  old_y,
    input  logic [2:0]  new_x,
    input  logic [2:0]  new_y,
    input  logic [3:0]  src_piece,
    input  logic [3:0]  dst_piece,
    output logic [5:0]  chk_start,
    output logic [2:0]  chk_old_x,
    output logic [2:0]  chk_old_y,
    output logic [2:0]  chk_new_x,
    output logic [2:0]  chk_new_y,
    output logic [2:0]  chk_h_delta,
    output logic [2:0]  chk_v_delta,
    input  logic [5:0]  chk_done,
    input  logic [5:0]  chk_legal,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_legal,
    output logic [2:0]  res_code,
    output logic [15:0] stat_legal_cnt,
    output logic [15:0] stat_illegal_cnt
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    fsm_state_e state_reg, state_next;
    logic [2:0] old_x_reg, old_y_reg, new_x_reg, new_y_reg;
    logic [3:0] src_reg, dst_reg;
    logic [2:0] h_delta_reg, v_delta_reg;
    logic [5:0] chk_start_reg;
    logic [7:0] to_cnt_reg;
    logic       res_legal_reg;
    logic [2:0] res_code_reg;

    logic [2:0] pre_h_delta, pre_v_delta, pre_code;
    logic       pre_reject;
    logic [5:0] kind_onehot;
    logic       done_sel, legal_sel, timeout_hit, accept;

    move_precheck u_precheck (
        .old_x       (old_x_reg),
        .old_y       (old_y_reg),
        .new_x       (new_x_reg),
        .new_y       (new_y_reg),
        .src_piece   (src_reg),
        .dst_piece   (dst_reg),
        .h_delta     (pre_h_delta),
        .v_delta     (pre_v_delta),
        .reject      (pre_reject),
        .reject_code (pre_code)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHECKERS; gi++) begin : g_kind
            assign kind_onehot[gi] = (src_reg[2:0] == 3'(gi));
        end
    endgenerate

    // Only the dispatched checker's flags matter; stray done bits are masked off here.
    assign done_sel    = |(chk_done & kind_onehot);
    assign legal_sel   = |(chk_legal & kind_onehot);
    assign timeout_hit = (to_cnt_reg == TO_LAST);
    assign req_ready   = (state_reg == IDLE) && !reset;
    assign accept      = req_valid && req_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (accept) state_next = PRECHECK;
            PRECHECK: state_next = pre_reject ? RESP : DISPATCH;
            DISPATCH: state_next = WAIT;
            WAIT:     if (done_sel || timeout_hit) state_next = RESP;
            RESP:     if (res_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            old_x_reg     <= '0;
            old_y_reg     <= '0;
            new_x_reg     <= '0;
            new_y_reg     <= '0;
            src_reg       <= '0;
            dst_reg       <= '0;
            h_delta_reg   <= '0;
            v_delta_reg   <= '0;
            chk_start_reg <= '0;
            to_cnt_reg    <= '0;
            res_legal_reg <= 1'b0;
            res_code_reg  <= OK;
        end else begin
            state_reg     <= state_next;
            chk_start_reg <= (state_next == DISPATCH) ? kind_onehot : 6'd0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        old_x_reg <= old_x;
                        old_y_reg <= old_y;
                        new_x_reg <= new_x;
                        new_y_reg <= new_y;
                        src_reg   <= src_piece;
                        dst_reg   <= dst_piece;
                    end
                end
                PRECHECK: begin
                    h_delta_reg <= pre_h_delta;
                    v_delta_reg <= pre_v_delta;
                    if (pre_reject) begin
                        res_legal_reg <= 1'b0;
                        res_code_reg  <= pre_code;
                    end
                end
                DISPATCH: to_cnt_reg <= '0;
                WAIT: begin
                    // A done seen on the final timeout cycle still wins.
                    if (done_sel) begin
                        res_legal_reg <= legal_sel;
                        res_code_reg  <= legal_sel ? OK : REJECTED;
                    end else if (timeout_hit) begin
                        res_legal_reg <= 1'b0;
                        res_code_reg  <= TIMEOUT;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign chk_start   = chk_start_reg;
    assign chk_old_x   = old_x_reg;
    assign chk_old_y   = old_y_reg;
    assign chk_new_x   = new_x_reg;
    assign chk_new_y   = new_y_reg;
    assign chk_h_delta = h_delta_reg;
    assign chk_v_delta = v_delta_reg;
    assign res_valid   = (state_reg == RESP);
    assign res_legal   = res_legal_reg;
    assign res_code    = res_code_reg;

`ifdef MOVE_CHECK_STATS_EN
    logic [15:0] stat_legal_reg, stat_illegal_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_legal_reg   <= '0;
            stat_illegal_reg <= '0;
        end else if (res_valid && res_ready) begin
            if (res_legal_reg) begin
                if (stat_legal_reg != 16'hFFFF) stat_legal_reg <= stat_legal_reg + 16'd1;
            end else begin
                if (stat_illegal_reg != 16'hFFFF) stat_illegal_reg <= stat_illegal_reg + 16'd1;
            end
        end
    end

    assign stat_legal_cnt   = stat_legal_reg;
    assign stat_illegal_cnt = stat_illegal_reg;
`else
    assign stat_legal_cnt   = 16'd0;
    assign stat_illegal_cnt = 16'd0;
`endif

endmodule

// File: doc/move_check_ctrl.md
MOVE_CHECK_CTRL -- requirements
Module: move_check_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum cycles spent in WAIT before a timeout (range 2-255).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req_valid  in  1 / req_ready  out  1  move-request handshake.
REQ-005 SHALL have ports: old_x, old_y, new_x, new_y  in  3 each  source and destination squares.
REQ-006 SHALL have ports: src_piece, dst_piece  in  4 each  board contents at the source and destination; 4'd15 means empty.
REQ-007 SHALL have ports: chk_start  out  6  one-hot start pulse (bit0 pawn, 1 knight, 2 bishop, 3 rook, 4 queen, 5 king).
REQ-008 SHALL have ports: chk_old_x/y, chk_new_x/y  out  3 each, and chk_h_delta, chk_v_delta  out  3 each  registered operands broadcast to all checkers.
REQ-009 SHALL have ports: chk_done, chk_legal  in  6 each  per-checker done and legal flags, level or pulse.
REQ-010 SHALL have ports: res_valid  out  1 / res_ready  in  1 / res_legal  out  1 / res_code  out  3  result handshake.
REQ-011 SHALL have ports: stat_legal_cnt, stat_illegal_cnt  out  16 each  move statistics.

Function
REQ-012 Piece encoding SHALL be bit3 = colour and bits[2:0] = kind (0 pawn to 5 king); kinds 6 and 7 are invalid, except that 4'd15 means empty.
REQ-013 FSM states SHALL be IDLE, PRECHECK, DISPATCH, WAIT, RESP.
REQ-014 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid & req_ready, all inputs are registered, and the next state is PRECHECK.
REQ-015 PRECHECK SHALL compute h_delta = |new_x-old_x| and v_delta = |new_y-old_y| into the chk_*delta registers and evaluate the reject checks, with the first match winning.
  - Code 1: same square.
  - Code 2: src_piece == 15.
  - Code 4: src kind is 6 or 7.
  - Code 3: dst_piece != 15 and has the same colour bit as src.
  - Any match goes to RESP with res_legal = 0; otherwise the next state is DISPATCH.
REQ-016 DISPATCH SHALL drive chk_start[kind] = 1 for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-017 WAIT SHALL sample only chk_done[kind]; done bits of other checkers are ignored.
REQ-018 In WAIT, if chk_done[kind] = 1, the FSM SHALL capture res_legal = chk_legal[kind], set res_code = 0 if legal or 5 if not, and go to RESP.
REQ-019 In WAIT, a cycle without done SHALL increment the counter; when the counter reaches TIMEOUT_CYCLES-1 without done, the result SHALL be res_legal = 0 with code 6.
REQ-020 If done and the timeout occur in the same cycle, done SHALL win.
REQ-021 RESP SHALL hold res_valid = 1 with res_legal and res_code stable until res_ready = 1, then return to IDLE; this gives no back-to-back acceptance, so req_ready first rises in the cycle after the handshake.
REQ-022 Latency from acceptance edge to res_valid SHALL be:
  - Reject path: 2 cycles.
  - Checker path: 3 + n cycles, where n is the number of WAIT cycles before done is seen.
REQ-023 chk_start SHALL be 0 in every state except DISPATCH.
REQ-024 chk_* operands SHALL be stable from PRECHECK until RESP exits.

Reset
REQ-025 reset SHALL force IDLE and clear all of the following in the same edge, whatever the state (including WAIT or RESP):
  - req_ready = 0 during reset, 1 on the first cycle after reset;
  - res_valid, res_legal, res_code, chk_start;
  - all chk_* operands, the timeout counter, and both statistics counters.
REQ-026 A checker done arriving after a reset that aborts WAIT SHALL be ignored.

Configuration
REQ-027 With macro MOVE_CHECK_STATS_EN defined, the statistics counters SHALL behave as follows.
  - stat_legal_cnt increments on each RESP handshake with res_legal = 1.
  - stat_illegal_cnt increments on each RESP handshake with res_legal = 0.
  - Both counters saturate at 16'hFFFF.
REQ-028 Without MOVE_CHECK_STATS_EN, both statistics ports SHALL remain present and tied to 0, with no counter logic.

Structure
REQ-029 A shared package chess_pkg SHALL hold:
  - the piece-kind enum, the EMPTY = 4'd15 constant and the colour-bit index;
  - the result-code enum (OK = 0, SAME_SQ = 1, EMPTY_SRC = 2, OWN_CAPTURE = 3, BAD_PIECE = 4, REJECTED = 5, TIMEOUT = 6);
  - the FSM state typedef.
REQ-030 The abs-delta and reject-check logic SHALL be the sub-module move_precheck, which is combinational and instantiated once.

Verification
REQ-031 The bench SHALL cover these directed scenarios.
  - Pawn (src 4'd0) from (3,6) to (3,4), dst 15 -> chk_start = 6'b000001 for 1 cycle with h_delta = 0, v_delta = 2; chk_done[0] = 1 and chk_legal[0] = 1 on the 2nd WAIT cycle -> res_valid with legal = 1, code 0.
  - src = 15 -> res_valid 2 cycles after acceptance, code 2, chk_start never asserted.
  - White rook (4'd3) capturing white knight (4'd1) -> code 3.
  - Knight request while only chk_done[3] pulses -> the stray done is ignored; with TIMEOUT_CYCLES = 4, result is code 6 after 4 WAIT cycles.
  - res_ready held low for 10 cycles -> res_valid, res_legal, res_code stable and req_ready = 0 throughout.
  - Reset asserted mid-WAIT, then a late chk_done -> FSM in IDLE, res_valid stays 0; with MOVE_CHECK_STATS_EN, the counters read 0 and then 1/1 after one legal and one illegal move.
